// File: rtl/id_ex_issue_if.sv
// ---------------------------------------------------------------------------
// id_ex_issue_if
//   Bundles the ID-stage inputs, the writeback forwarding sources and the
//   registered EX-stage outputs of the ID/EX issue register.
//
//   slave  : used by id_ex_issue (takes ID/forward inputs, drives EX outputs)
//   master : used by the decode side / testbench (drives ID inputs)
//
//   Signals
//     id_valid, id_instr, id_rs_data, id_rt_data : ID stage instruction+data
//     stall, flush                               : EX register control
//     exm_we/exm_wreg/exm_data                   : EX/MEM forward source
//     mw_we/mw_wreg/mw_data                      : MEM/WB forward source
//     ex_*                                       : registered EX stage fields
//     hz_ldstall                                 : combinational load-use hazard
// ---------------------------------------------------------------------------
interface id_ex_issue_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        exm_we;
  logic [4:0]  exm_wreg;
  logic [31:0] exm_data;
  logic        mw_we;
  logic [4:0]  mw_wreg;
  logic [31:0] mw_data;

  logic        ex_valid;
  logic [4:0]  ex_aluct;
  logic        ex_sign;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [31:0] ex_stdata;
  logic [4:0]  ex_wreg;
  logic        ex_we;
  logic        ex_memrd;
  logic        ex_memwr;
  logic        ex_ill;
  logic        hz_ldstall;

  modport slave (
    input  id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
           exm_we, exm_wreg, exm_data, mw_we, mw_wreg, mw_data,
    output ex_valid, ex_aluct, ex_sign, ex_shamt, ex_in1, ex_in2, ex_stdata,
           ex_wreg, ex_we, ex_memrd, ex_memwr, ex_ill, hz_ldstall
  );

  modport master (
    output id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
           exm_we, exm_wreg, exm_data, mw_we, mw_wreg, mw_data,
    input  ex_valid, ex_aluct, ex_sign, ex_shamt, ex_in1, ex_in2, ex_stdata,
           ex_wreg, ex_we, ex_memrd, ex_memwr, ex_ill, hz_ldstall
  );
endinterface

// File: rtl/id_ex_issue.sv
// ---------------------------------------------------------------------------
// id_ex_issue
//   ID/EX issue register of the 32-bit MIPS pipeline. Decodes the ID-stage
//   instruction into ALU control, signedness, shift amount and forwarded
//   operands, registers them into EX with stall/flush/bubble control, and
//   flags load-use hazards against the load currently held in EX.
//
//   Ports
//     clk   : pipeline clock, rising edge
//     reset : synchronous, active-high; loads a bubble
//     bus   : id_ex_issue_if.slave (ID inputs, forward sources, EX outputs)
// ---------------------------------------------------------------------------
module id_ex_issue (
  input  logic           clk,
  input  logic           reset,
  id_ex_issue_if.slave   bus
);

  localparam int DATA_W = 32;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_SRL = 5'b11000;
  localparam logic [4:0] ALU_SRA = 5'b11001;
  localparam logic [4:0] ALU_LUI = 5'b11010;

  // EX/MEM wins over MEM/WB; register 0 always reads the ID data.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] id_data,
    input logic              xm_we,
    input logic [4:0]        xm_wreg,
    input logic [DATA_W-1:0] xm_data,
    input logic              wb_we,
    input logic [4:0]        wb_wreg,
    input logic [DATA_W-1:0] wb_data
  );
    if (src == 5'd0)                     return id_data;
    else if (xm_we && (xm_wreg == src))  return xm_data;
    else if (wb_we && (wb_wreg == src))  return wb_data;
    else                                 return id_data;
  endfunction

  // ---- stage p0: ID decode and forwarding (combinational) ----
  logic [5:0]        opcode_p0;
  logic [5:0]        funct_p0;
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [4:0]        rd_p0;
  logic [4:0]        sh_p0;
  logic [15:0]       imm_p0;
  logic [DATA_W-1:0] simm_p0;
  logic [DATA_W-1:0] zimm_p0;
  logic [DATA_W-1:0] fwd_rs_p0;
  logic [DATA_W-1:0] fwd_rt_p0;

  assign opcode_p0 = bus.id_instr[31:26];
  assign rs_p0     = bus.id_instr[25:21];
  assign rt_p0     = bus.id_instr[20:16];
  assign rd_p0     = bus.id_instr[15:11];
  assign sh_p0     = bus.id_instr[10:6];
  assign funct_p0  = bus.id_instr[5:0];
  assign imm_p0    = bus.id_instr[15:0];
  assign simm_p0   = {{16{imm_p0[15]}}, imm_p0};
  assign zimm_p0   = {16'h0000, imm_p0};

  assign fwd_rs_p0 = fwd_sel(rs_p0, bus.id_rs_data, bus.exm_we, bus.exm_wreg,
                             bus.exm_data, bus.mw_we, bus.mw_wreg, bus.mw_data);
  assign fwd_rt_p0 = fwd_sel(rt_p0, bus.id_rt_data, bus.exm_we, bus.exm_wreg,
                             bus.exm_data, bus.mw_we, bus.mw_wreg, bus.mw_data);

  logic              legal_p0;
  logic [4:0]        aluct_p0;
  logic              sign_p0;
  logic [4:0]        shamt_p0;
  logic [DATA_W-1:0] in1_p0;
  logic [DATA_W-1:0] in2_p0;
  logic [4:0]        wreg_p0;
  logic              we_p0;
  logic              memrd_p0;
  logic              memwr_p0;
  logic              use_rs_p0;
  logic              use_rt_p0;

  always_comb begin
    legal_p0  = 1'b0;
    aluct_p0  = ALU_AND;
    sign_p0   = 1'b0;
    shamt_p0  = 5'd0;
    in1_p0    = '0;
    in2_p0    = '0;
    wreg_p0   = 5'd0;
    we_p0     = 1'b0;
    memrd_p0  = 1'b0;
    memwr_p0  = 1'b0;
    use_rs_p0 = 1'b0;
    use_rt_p0 = 1'b0;

    if (opcode_p0 == 6'h00) begin
      legal_p0  = 1'b1;
      in1_p0    = fwd_rs_p0;
      in2_p0    = fwd_rt_p0;
      wreg_p0   = rd_p0;
      we_p0     = 1'b1;
      use_rs_p0 = 1'b1;
      use_rt_p0 = 1'b1;
      case (funct_p0)
        6'h20, 6'h21: aluct_p0 = ALU_ADD;
        6'h22, 6'h23: aluct_p0 = ALU_SUB;
        6'h24:        aluct_p0 = ALU_AND;
        6'h25:        aluct_p0 = ALU_OR;
        6'h26:        aluct_p0 = ALU_XOR;
        6'h27:        aluct_p0 = ALU_NOR;
        6'h2A: begin aluct_p0 = ALU_SLT; sign_p0 = 1'b1; end
        6'h2B:        aluct_p0 = ALU_SLT;
        // Immediate shifts take shamt from the instruction and ignore rs.
        6'h00: begin aluct_p0 = ALU_SLL; shamt_p0 = sh_p0; use_rs_p0 = 1'b0; end
        6'h02: begin aluct_p0 = ALU_SRL; shamt_p0 = sh_p0; use_rs_p0 = 1'b0; end
        6'h03: begin aluct_p0 = ALU_SRA; shamt_p0 = sh_p0; use_rs_p0 = 1'b0; end
        // Variable shifts take shamt from the forwarded rs value.
        6'h04: begin aluct_p0 = ALU_SLL; shamt_p0 = fwd_rs_p0[4:0]; end
        6'h06: begin aluct_p0 = ALU_SRL; shamt_p0 = fwd_rs_p0[4:0]; end
        6'h07: begin aluct_p0 = ALU_SRA; shamt_p0 = fwd_rs_p0[4:0]; end
        default:      legal_p0 = 1'b0;
      endcase
    end else begin
      legal_p0  = 1'b1;
      in1_p0    = fwd_rs_p0;
      in2_p0    = simm_p0;
      wreg_p0   = rt_p0;
      we_p0     = 1'b1;
      use_rs_p0 = 1'b1;
      case (opcode_p0)
        6'h08, 6'h09: aluct_p0 = ALU_ADD;
        6'h0A: begin aluct_p0 = ALU_SLT; sign_p0 = 1'b1; end
        6'h0B:        aluct_p0 = ALU_SLT;
        6'h0C: begin aluct_p0 = ALU_AND; in2_p0 = zimm_p0; end
        6'h0D: begin aluct_p0 = ALU_OR;  in2_p0 = zimm_p0; end
        6'h0E: begin aluct_p0 = ALU_XOR; in2_p0 = zimm_p0; end
        6'h0F: begin aluct_p0 = ALU_LUI; in2_p0 = zimm_p0; use_rs_p0 = 1'b0; end
        6'h23: begin aluct_p0 = ALU_ADD; memrd_p0 = 1'b1; end
        // Store reads rt as data and writes no register.
        6'h2B: begin aluct_p0 = ALU_ADD; memwr_p0 = 1'b1; we_p0 = 1'b0; use_rt_p0 = 1'b1; end
        default:      legal_p0 = 1'b0;
      endcase
    end

    // Illegal encodings carry no operation, operands or register use.
    if (!legal_p0) begin
      aluct_p0  = ALU_AND;
      sign_p0   = 1'b0;
      shamt_p0  = 5'd0;
      in1_p0    = '0;
      in2_p0    = '0;
      wreg_p0   = 5'd0;
      we_p0     = 1'b0;
      memrd_p0  = 1'b0;
      memwr_p0  = 1'b0;
      use_rs_p0 = 1'b0;
      use_rt_p0 = 1'b0;
    end
  end

  // ---- stage p1: ID/EX register ----
  logic              vld_p1;
  logic [4:0]        aluct_p1;
  logic              sign_p1;
  logic [4:0]        shamt_p1;
  logic [DATA_W-1:0] in1_p1;
  logic [DATA_W-1:0] in2_p1;
  logic [DATA_W-1:0] stdata_p1;
  logic [4:0]        wreg_p1;
  logic              we_p1;
  logic              memrd_p1;
  logic              memwr_p1;
  logic              ill_p1;
  logic              hz_p0;

  // Depends only on EX register state and ID inputs, never on stall/flush.
  assign hz_p0 = vld_p1 && memrd_p1 && (wreg_p1 != 5'd0) && bus.id_valid &&
                 ((use_rs_p0 && (rs_p0 == wreg_p1)) ||
                  (use_rt_p0 && (rt_p0 == wreg_p1)));

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      vld_p1    <= 1'b0;
      aluct_p1  <= 5'd0;
      sign_p1   <= 1'b0;
      shamt_p1  <= 5'd0;
      in1_p1    <= '0;
      in2_p1    <= '0;
      stdata_p1 <= '0;
      wreg_p1   <= 5'd0;
      we_p1     <= 1'b0;
      memrd_p1  <= 1'b0;
      memwr_p1  <= 1'b0;
      ill_p1    <= 1'b0;
    end else if (!bus.stall) begin
      if (hz_p0 || !bus.id_valid) begin
        vld_p1    <= 1'b0;
        aluct_p1  <= 5'd0;
        sign_p1   <= 1'b0;
        shamt_p1  <= 5'd0;
        in1_p1    <= '0;
        in2_p1    <= '0;
        stdata_p1 <= '0;
        wreg_p1   <= 5'd0;
        we_p1     <= 1'b0;
        memrd_p1  <= 1'b0;
        memwr_p1  <= 1'b0;
        ill_p1    <= 1'b0;
      end else begin
        vld_p1    <= 1'b1;
        aluct_p1  <= aluct_p0;
        sign_p1   <= sign_p0;
        shamt_p1  <= shamt_p0;
        in1_p1    <= in1_p0;
        in2_p1    <= in2_p0;
        stdata_p1 <= fwd_rt_p0;
        wreg_p1   <= wreg_p0;
        we_p1     <= we_p0;
        memrd_p1  <= memrd_p0;
        memwr_p1  <= memwr_p0;
        ill_p1    <= !legal_p0;
      end
    end
  end

  assign bus.ex_valid   = vld_p1;
  assign bus.ex_aluct   = aluct_p1;
  assign bus.ex_sign    = sign_p1;
  assign bus.ex_shamt   = shamt_p1;
  assign bus.ex_in1     = in1_p1;
  assign bus.ex_in2     = in2_p1;
  assign bus.ex_stdata  = stdata_p1;
  assign bus.ex_wreg    = wreg_p1;
  assign bus.ex_we      = we_p1;
  assign bus.ex_memrd   = memrd_p1;
  assign bus.ex_memwr   = memwr_p1;
  assign bus.ex_ill     = ill_p1;
  assign bus.hz_ldstall = hz_p0;

endmodule

// File: tb/tb_id_ex_issue.sv
// ---------------------------------------------------------------------------
// tb_id_ex_issue
//   Directed bench for id_ex_issue. Each step drives ID inputs, pushes the
//   hand-derived EX contents expected after the next edge into a queue, and
//   pops/compares once the edge has passed.
// ---------------------------------------------------------------------------
module tb_id_ex_issue;

  logic clk;
  logic reset;

  id_ex_issue_if bus ();

  id_ex_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  aluct;
    logic        sign;
    logic [4:0]  shamt;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] stdata;
    logic [4:0]  wreg;
    logic        we;
    logic        memrd;
    logic        memwr;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    return e;
  endfunction

  // Valid, register-writing op; callers adjust the remaining fields.
  function automatic exp_t op(input logic [4:0] aluct, input logic [31:0] in1,
                              input logic [31:0] in2, input logic [31:0] stdata,
                              input logic [4:0] wreg);
    exp_t e;
    e        = '0;
    e.valid  = 1'b1;
    e.we     = 1'b1;
    e.aluct  = aluct;
    e.in1    = in1;
    e.in2    = in2;
    e.stdata = stdata;
    e.wreg   = wreg;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  task automatic check_ex(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".valid"},  bus.ex_valid,  e.valid);
      chk({tag, ".aluct"},  bus.ex_aluct,  e.aluct);
      chk({tag, ".sign"},   bus.ex_sign,   e.sign);
      chk({tag, ".shamt"},  bus.ex_shamt,  e.shamt);
      chk({tag, ".in1"},    bus.ex_in1,    e.in1);
      chk({tag, ".in2"},    bus.ex_in2,    e.in2);
      chk({tag, ".stdata"}, bus.ex_stdata, e.stdata);
      chk({tag, ".wreg"},   bus.ex_wreg,   e.wreg);
      chk({tag, ".we"},     bus.ex_we,     e.we);
      chk({tag, ".memrd"},  bus.ex_memrd,  e.memrd);
      chk({tag, ".memwr"},  bus.ex_memwr,  e.memwr);
      chk({tag, ".ill"},    bus.ex_ill,    e.ill);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_ex(tag);
  endtask

  task automatic set_id(input logic vld, input logic [31:0] instr,
                        input logic [31:0] rs_d, input logic [31:0] rt_d);
    bus.id_valid   = vld;
    bus.id_instr   = instr;
    bus.id_rs_data = rs_d;
    bus.id_rt_data = rt_d;
  endtask

  task automatic set_fwd(input logic xw, input logic [4:0] xr, input logic [31:0] xd,
                         input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    bus.exm_we   = xw;
    bus.exm_wreg = xr;
    bus.exm_data = xd;
    bus.mw_we    = ww;
    bus.mw_wreg  = wr;
    bus.mw_data  = wd;
  endtask

  exp_t e_add, e_lw, e_tmp;

  initial begin
    // Reset held two cycles with a valid ADD presented.
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    q.push_back(bubble()); tick("reset0");
    chk("reset0.hz", bus.hz_ldstall, 1'b0);
    q.push_back(bubble()); tick("reset1");

    // First real instruction: ADD r3, r1, r2.
    reset = 1'b0;
    e_add = op(5'b00010, 32'd5, 32'd7, 32'd7, 5'd3);
    q.push_back(e_add); tick("add");

    // SRA r4, r2, 4 (rs field 0 so in1 is the raw ID data).
    set_id(1'b1, rtype(5'd0, 5'd2, 5'd4, 5'd4, 6'h03), 32'h55, 32'h8000_0000);
    e_tmp = op(5'b11001, 32'h55, 32'h8000_0000, 32'h8000_0000, 5'd4);
    e_tmp.shamt = 5'd4;
    q.push_back(e_tmp); tick("sra");

    // SRLV r4, r2, r1: shamt from rs[4:0] = 3.
    set_id(1'b1, rtype(5'd1, 5'd2, 5'd4, 5'd9, 6'h06), 32'h23, 32'hF0);
    e_tmp = op(5'b11000, 32'h23, 32'hF0, 32'hF0, 5'd4);
    e_tmp.shamt = 5'd3;
    q.push_back(e_tmp); tick("srlv");

    // NOR r4, r1, r2.
    set_id(1'b1, rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h27), 32'h1, 32'h2);
    q.push_back(op(5'b01100, 32'h1, 32'h2, 32'h2, 5'd4)); tick("nor");

    // SLTIU r6, r1, 0xFFFF: sign-extended, unsigned compare.
    set_id(1'b1, itype(6'h0B, 5'd1, 5'd6, 16'hFFFF), 32'd9, 32'h11);
    q.push_back(op(5'b00111, 32'd9, 32'hFFFF_FFFF, 32'h11, 5'd6)); tick("sltiu");

    // SLTI r6, r1, 0x10: signed compare.
    set_id(1'b1, itype(6'h0A, 5'd1, 5'd6, 16'h0010), 32'd9, 32'h11);
    e_tmp = op(5'b00111, 32'd9, 32'h10, 32'h11, 5'd6);
    e_tmp.sign = 1'b1;
    q.push_back(e_tmp); tick("slti");

    // ORI r7, r1, 0x8000: zero-extended.
    set_id(1'b1, itype(6'h0D, 5'd1, 5'd7, 16'h8000), 32'h3, 32'h0);
    q.push_back(op(5'b00001, 32'h3, 32'h0000_8000, 32'h0, 5'd7)); tick("ori");

    // LUI r8, 0x1234.
    set_id(1'b1, itype(6'h0F, 5'd0, 5'd8, 16'h1234), 32'h0, 32'h0);
    q.push_back(op(5'b11010, 32'h0, 32'h0000_1234, 32'h0, 5'd8)); tick("lui");

    // Opcode 0x3F: illegal.
    set_id(1'b1, itype(6'h3F, 5'd0, 5'd0, 16'h5A5A), 32'h0, 32'h0);
    e_tmp = bubble();
    e_tmp.valid = 1'b1;
    e_tmp.ill   = 1'b1;
    q.push_back(e_tmp); tick("illegal");

    // SW r0, -4(r1): store, no register write.
    set_id(1'b1, itype(6'h2B, 5'd1, 5'd0, 16'hFFFC), 32'h100, 32'hDEAD);
    e_tmp = op(5'b00010, 32'h100, 32'hFFFF_FFFC, 32'hDEAD, 5'd0);
    e_tmp.we    = 1'b0;
    e_tmp.memwr = 1'b1;
    q.push_back(e_tmp); tick("sw");

    // Forwarding: both sources target r4, EX/MEM wins.
    set_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
    set_id(1'b1, rtype(5'd4, 5'd5, 5'd9, 5'd0, 6'h20), 32'h44, 32'h55);
    q.push_back(op(5'b00010, 32'hAA, 32'h55, 32'h55, 5'd9)); tick("fwd_prio");

    // rs from EX/MEM, rt from MEM/WB (also reaches store data).
    set_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd5, 32'hBB);
    q.push_back(op(5'b00010, 32'hAA, 32'hBB, 32'hBB, 5'd9)); tick("fwd_split");

    // Register 0 is never forwarded.
    set_fwd(1'b1, 5'd0, 32'hCC, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, rtype(5'd0, 5'd5, 5'd9, 5'd0, 6'h20), 32'h1234, 32'h55);
    q.push_back(op(5'b00010, 32'h1234, 32'h55, 32'h55, 5'd9)); tick("fwd_r0");
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Load-use: LW r2, 8(r1) into EX.
    set_id(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0008), 32'h200, 32'h0);
    e_lw = op(5'b00010, 32'h200, 32'h8, 32'h0, 5'd2);
    e_lw.memrd = 1'b1;
    q.push_back(e_lw); tick("lw");
    set_id(1'b1, rtype(5'd0, 5'd2, 5'd5, 5'd3, 6'h00), 32'h0, 32'h0);
    #1 chk("hz_sll_rt", bus.hz_ldstall, 1'b1);
    set_id(1'b1, itype(6'h0F, 5'd2, 5'd2, 16'h0001), 32'h77, 32'h0);
    #1 chk("hz_lui", bus.hz_ldstall, 1'b0);
    set_id(1'b0, rtype(5'd2, 5'd1, 5'd5, 5'd0, 6'h20), 32'h0, 32'h0);
    #1 chk("hz_novalid", bus.hz_ldstall, 1'b0);
    set_id(1'b1, rtype(5'd2, 5'd1, 5'd5, 5'd0, 6'h20), 32'h0, 32'h0);
    #1 chk("hz_add_rs", bus.hz_ldstall, 1'b1);
    q.push_back(bubble()); tick("hz_bubble");
    chk("hz_after_bubble", bus.hz_ldstall, 1'b0);

    // Stall for 3 cycles holds EX while ID changes.
    set_id(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    q.push_back(e_add); tick("pre_stall");
    bus.stall = 1'b1;
    set_id(1'b1, itype(6'h0E, 5'd1, 5'd9, 16'hFFFF), 32'h999, 32'h888);
    for (int i = 0; i < 3; i++) begin
      q.push_back(e_add); tick("stall_hold");
    end

    // Stall with a load-use hazard present: hold, no bubble.
    bus.stall = 1'b0;
    set_id(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0008), 32'h200, 32'h0);
    q.push_back(e_lw); tick("lw2");
    bus.stall = 1'b1;
    set_id(1'b1, rtype(5'd2, 5'd1, 5'd5, 5'd0, 6'h20), 32'h0, 32'h0);
    #1 chk("hz_stalled", bus.hz_ldstall, 1'b1);
    q.push_back(e_lw); tick("stall_hz_hold");

    // Flush beats stall.
    bus.flush = 1'b1;
    q.push_back(bubble()); tick("flush_stall");
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Reset asserted mid-stall.
    set_id(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    q.push_back(e_add); tick("pre_reset");
    bus.stall = 1'b1;
    reset     = 1'b1;
    q.push_back(bubble()); tick("reset_stall");
    reset     = 1'b0;
    bus.stall = 1'b0;

    // id_valid low loads a bubble.
    q.push_back(e_add); tick("reload");
    set_id(1'b0, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    q.push_back(bubble()); tick("idle_bubble");

    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

- Decode stage to execute stage issue register of the MIPS pipeline; the control and operand producer for the ALU.
- Decodes the ID-stage instruction into the ALU control code, signedness flag, shift amount and both operands, with EX/MEM and MEM/WB forwarding applied.
- Registers the result at the ID/EX boundary with stall, flush and bubble control.
- Detects load-use hazards against the instruction currently held in EX.

## Interface
Parameters: none; all widths are fixed by the 32-bit MIPS datapath.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction word
- id_rs_data, id_rt_data  in  32 each  register-file read data
- stall  in  1  downstream stall; hold EX register
- flush  in  1  squash; load bubble into EX
- exm_we, exm_wreg, exm_data  in  1/5/32  EX/MEM writeback forward source
- mw_we, mw_wreg, mw_data  in  1/5/32  MEM/WB writeback forward source
- ex_valid  out  1  EX holds a real instruction
- ex_aluct  out  5  ALU operation code
- ex_sign  out  1  signed compare select
- ex_shamt  out  5  shift amount
- ex_in1, ex_in2  out  32 each  ALU operands
- ex_stdata  out  32  forwarded rt, used as store data
- ex_wreg  out  5  destination register
- ex_we  out  1  register write enable
- ex_memrd, ex_memwr  out  1 each  load / store
- ex_ill  out  1  unsupported instruction
- hz_ldstall  out  1  load-use hazard; combinational

## Operation
ALU codes: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001, LUI 11010.

R-type (opcode 0x00): ex_in1 = fwd rs, ex_in2 = fwd rt, wreg = rd, we = 1. Decode by funct:
- 0x20/0x21 ADD
- 0x22/0x23 SUB
- 0x24 AND
- 0x25 OR
- 0x26 XOR
- 0x27 NOR
- 0x2A SLT, sign = 1
- 0x2B SLT, sign = 0
- 0x00/0x02/0x03 SLL/SRL/SRA, shamt = instr[10:6]
- 0x04/0x06/0x07 SLL/SRL/SRA, shamt = fwd rs[4:0]

I-type: ex_in1 = fwd rs, ex_in2 = immediate, wreg = rt, we = 1. Immediate is sign-extended unless noted. Decode by opcode:
- 0x08/0x09 ADD
- 0x0A SLT, sign = 1
- 0x0B SLT, sign = 0
- 0x0C AND, zero-extended
- 0x0D OR, zero-extended
- 0x0E XOR, zero-extended
- 0x0F LUI, zero-extended
- 0x23 ADD, memrd = 1
- 0x2B ADD, memwr = 1, we = 0

Fields not listed above are 0, including sign and shamt.

Any other opcode/funct with id_valid = 1 is illegal:
- ex_valid = 1, ex_ill = 1
- ex_aluct = 00000
- ex_we = ex_memrd = ex_memwr = 0

Forwarding, evaluated per source register s (rs or rt):
- If s = 0: use the ID data unchanged.
- Else if exm_we and exm_wreg == s: use exm_data.
- Else if mw_we and mw_wreg == s: use mw_data.
- Else use the ID data.
- ex_stdata always takes the forwarded rt value.

hz_ldstall = ex_valid & ex_memrd & (ex_wreg != 0) & id_valid & (match_rs | match_rt).
- rs is used by all decoded instructions except SLL/SRL/SRA (funct 0x00/0x02/0x03) and LUI.
- rt is used by all R-type instructions and by store (0x2B).
- Illegal instructions use neither.
- ID-stage hold on this signal is performed upstream.

EX register update, priority highest first:
1. reset: bubble
2. flush: bubble
3. stall: hold all outputs
4. hz_ldstall: bubble
5. id_valid = 0: bubble
6. otherwise: load the decoded values

Bubble = every registered output 0.

## Timing
- Reset: all registered outputs are 0 one edge after reset is sampled high; hz_ldstall is therefore 0.
- Latency: one cycle, ID inputs to EX outputs. Forwarding sources are sampled in the same cycle as the ID inputs.
- flush with stall both high: bubble, because flush wins.
- Reset asserted mid-stall: bubble.
- stall with hz_ldstall both high: hold, with no bubble.
- hz_ldstall depends only on EX register state and current ID inputs; there is no combinational path from stall or flush.
- Forward priority: EX/MEM over MEM/WB on the same register. Register 0 is never forwarded.

## Test plan
- Reset: reset = 1 for 2 cycles with id_valid = 1 and an ADD applied; all outputs 0. Release reset with ADD r3, r1, r2 (rs 5, rt 7); next cycle ex_aluct = 00010, ex_in1 = 5, ex_in2 = 7, ex_wreg = 3, ex_we = 1.
- Decode sweep:
  - SRA with instr[10:6] = 4: ex_aluct = 11001, ex_shamt = 4.
  - SLTIU with immediate 0xFFFF: ex_in2 = 0xFFFFFFFF, ex_sign = 0.
  - ORI with immediate 0x8000: ex_in2 = 0x00008000.
  - LUI with immediate 0x1234: ex_aluct = 11010.
  - Opcode 0x3F: ex_ill = 1, ex_we = 0.
- Forwarding: ID rs = 4 with exm_wreg = 4 (exm_data 0xAA) and mw_wreg = 4 (mw_data 0xBB) ⇒ ex_in1 = 0xAA. With rs = 0 and exm_wreg = 0 ⇒ ex_in1 = id_rs_data.
- Load-use: lw r2 in EX, then add r5, r2, r1 in ID ⇒ hz_ldstall = 1 and EX loads a bubble next cycle. sll r5, r2, 3 in ID instead ⇒ hz_ldstall = 1 (rt used). lui r2 in ID instead ⇒ hz_ldstall = 0.
- Stall/flush: stall = 1 for 3 cycles ⇒ EX outputs constant. stall = flush = 1 ⇒ bubble next cycle. stall = 1 with hz_ldstall = 1 ⇒ hold, not bubble.
